// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package stall_ctrl_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned WAIT_MAX_DEF    = 255;
    localparam int unsigned WAIT_CNT_W      = 8;

    typedef enum logic [0:0] {
        MemIdle = 1'b0,
        MemWait = 1'b1
    } mem_state_e;

    // A source operand depends on dst only if it is actually read and dst is not $zero.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic rd_en);
        return rd_en && (src == dst) && (dst != 5'd0);
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Hazard-controller bus: pipeline-stage hazard information in, stall/clear controls out.
interface stall_ctrl_if;

    logic [4:0] RsD;
    logic [4:0] RtD;
    logic       UseRsD;
    logic       UseRtD;
    logic       BranchD;
    logic       MduUseD;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] RegAddrE;
    logic       MemtoRegM;
    logic [4:0] RegAddrM;
    logic       MduStartE;
    logic       MduDivE;
    logic       DmReqM;
    logic       DmReadyM;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       StallW;
    logic       ClrE;
    logic       ClrW;
    logic       MduBusy;
    logic       MemTimeout;

    modport master (
        output RsD, RtD, UseRsD, UseRtD, BranchD, MduUseD, RegWriteE, MemtoRegE, RegAddrE,
               MemtoRegM, RegAddrM, MduStartE, MduDivE, DmReqM, DmReadyM,
        input  StallF, StallD, StallE, StallM, StallW, ClrE, ClrW, MduBusy, MemTimeout
    );

    modport slave (
        input  RsD, RtD, UseRsD, UseRtD, BranchD, MduUseD, RegWriteE, MemtoRegE, RegAddrE,
               MemtoRegM, RegAddrM, MduStartE, MduDivE, DmReqM, DmReadyM,
        output StallF, StallD, StallE, StallM, StallW, ClrE, ClrW, MduBusy, MemTimeout
    );

endinterface

// File: rtl/stall_ctrl_mdu_busy_counter.sv
// Multiply/divide busy counter: loads the op latency on an accepted start, counts down to idle.
module stall_ctrl_mdu_busy_counter
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A start while already counting is ignored; the D-stage stall should prevent it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (start) begin
            cnt_d = div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Central hazard controller for the 5-stage pipeline: load-use, branch-operand, MDU and
// data-memory-wait stalls. Optional STALL_STATS_EN adds StallCnt/MemWaitCnt counters.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned WAIT_MAX    = WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef STALL_STATS_EN
    output logic [31:0] StallCnt,
    output logic [31:0] MemWaitCnt,
`endif
    stall_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WaitMax = WAIT_CNT_W'(WAIT_MAX);

    logic match_e, match_m;
    logic lw_stall, br_stall, mdu_stall, mem_stall, hz_stall;
    logic mdu_busy;
    logic stall_f, stall_d, stall_e, stall_m, stall_w, clr_e, clr_w;

    mem_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  timeout_q, timeout_d;

    assign match_e = reg_match(bus.RsD, bus.RegAddrE, bus.UseRsD) |
                     reg_match(bus.RtD, bus.RegAddrE, bus.UseRtD);
    assign match_m = reg_match(bus.RsD, bus.RegAddrM, bus.UseRsD) |
                     reg_match(bus.RtD, bus.RegAddrM, bus.UseRtD);

    assign lw_stall  = bus.MemtoRegE & bus.RegWriteE & match_e;
    assign br_stall  = bus.BranchD & ((bus.RegWriteE & match_e) | (bus.MemtoRegM & match_m));
    assign mdu_stall = bus.MduUseD & (mdu_busy | bus.MduStartE);
    assign mem_stall = bus.DmReqM & ~bus.DmReadyM;
    assign hz_stall  = lw_stall | br_stall | mdu_stall;

    // A memory wait freezes everything up to MEM and bubbles WB; other hazards wait behind it.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        clr_e   = 1'b0;
        clr_w   = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                clr_w   = 1'b1;
            end else if (hz_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                clr_e   = 1'b1;
            end
        end
    end

    stall_ctrl_mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_cnt (
        .clk   (clk),
        .reset (reset),
        .start (bus.MduStartE & ~stall_e),
        .div   (bus.MduDivE),
        .busy  (mdu_busy)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            MemIdle: begin
                if (mem_stall) begin
                    state_d = MemWait;
                    wait_d  = '0;
                end
            end
            MemWait: begin
                if (bus.DmReadyM || !bus.DmReqM) begin
                    state_d = MemIdle;
                end else if (wait_q != WaitMax) begin
                    wait_d = wait_q + WAIT_CNT_W'(1);
                end
            end
            default: state_d = MemIdle;
        endcase
        if (wait_d == WaitMax) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MemIdle;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q, mem_wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            if (stall_d) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (mem_stall) begin
                mem_wait_cnt_q <= mem_wait_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt   = stall_cnt_q;
    assign MemWaitCnt = mem_wait_cnt_q;
`endif

    assign bus.StallF     = stall_f;
    assign bus.StallD     = stall_d;
    assign bus.StallE     = stall_e;
    assign bus.StallM     = stall_m;
    assign bus.StallW     = stall_w;
    assign bus.ClrE       = clr_e;
    assign bus.ClrW       = clr_w;
    assign bus.MduBusy    = mdu_busy & ~reset;
    assign bus.MemTimeout = timeout_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl; outputs sampled on the falling clock edge.
module tb_stall_ctrl;

    // Packed as {StallF, StallD, StallE, StallM, StallW, ClrE, ClrW}
    localparam logic [6:0] PatNone = 7'b0000000;
    localparam logic [6:0] PatHz   = 7'b1100010;
    localparam logic [6:0] PatMem  = 7'b1111001;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    stall_ctrl_if bus ();

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] mem_wait_cnt;
`endif

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
`ifdef STALL_STATS_EN
        .StallCnt   (stall_cnt),
        .MemWaitCnt (mem_wait_cnt),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat();
        return {25'd0, bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW,
                bus.ClrE, bus.ClrW};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.RsD = 5'd0;       bus.RtD = 5'd0;       bus.UseRsD = 1'b0;   bus.UseRtD = 1'b0;
        bus.BranchD = 1'b0;   bus.MduUseD = 1'b0;   bus.RegWriteE = 1'b0;
        bus.MemtoRegE = 1'b0; bus.RegAddrE = 5'd0;  bus.MemtoRegM = 1'b0;
        bus.RegAddrM = 5'd0;  bus.MduStartE = 1'b0; bus.MduDivE = 1'b0;
        bus.DmReqM = 1'b0;    bus.DmReadyM = 1'b0;
    endtask

    task automatic set_load_use();
        bus.MemtoRegE = 1'b1; bus.RegWriteE = 1'b1; bus.RegAddrE = 5'd8;
        bus.RsD = 5'd8;       bus.UseRsD = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        reset = 1'b1;

        // Outputs must stay quiet while reset is high, even with a live hazard
        set_load_use();
        bus.DmReqM = 1'b1;
        @(negedge clk);
        check("reset_pat", pat(), PatNone);
        check("reset_busy", 32'(bus.MduBusy), 0);
        tick();
        tick();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        check("idle_pat", pat(), PatNone);
        check("idle_timeout", 32'(bus.MemTimeout), 0);
        tick();

        // Load-use: one stall cycle, then the bubble clears E
        set_load_use();
        @(negedge clk);
        check("lu_stall", pat(), PatHz);
        tick();
        clear_inputs();
        @(negedge clk);
        check("lu_release", pat(), PatNone);
        tick();
        set_load_use();
        bus.RegAddrE = 5'd0;
        bus.RsD = 5'd0;
        @(negedge clk);
        check("lu_r0", pat(), PatNone);
        tick();
        set_load_use();
        bus.UseRsD = 1'b0;
        @(negedge clk);
        check("lu_unused", pat(), PatNone);
        tick();
        clear_inputs();

        // Branch operand from ALU op in E, then from load in M
        bus.BranchD = 1'b1; bus.RtD = 5'd9; bus.UseRtD = 1'b1;
        bus.RegWriteE = 1'b1; bus.RegAddrE = 5'd9;
        @(negedge clk);
        check("br_e", pat(), PatHz);
        tick();
        bus.RegWriteE = 1'b0; bus.RegAddrE = 5'd0;
        bus.MemtoRegM = 1'b1; bus.RegAddrM = 5'd9;
        @(negedge clk);
        check("br_m_load", pat(), PatHz);
        tick();
        bus.MemtoRegM = 1'b0;
        @(negedge clk);
        check("br_m_alu", pat(), PatNone);
        tick();
        clear_inputs();

        // Divide: busy for 10 cycles, stalls a dependent D instruction throughout
        bus.MduStartE = 1'b1; bus.MduDivE = 1'b1; bus.MduUseD = 1'b1;
        @(negedge clk);
        check("div_start_pat", pat(), PatHz);
        check("div_start_busy", 32'(bus.MduBusy), 0);
        tick();
        bus.MduStartE = 1'b0; bus.MduDivE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("div_busy%0d", i), 32'(bus.MduBusy), 1);
            check($sformatf("div_pat%0d", i), pat(), PatHz);
            tick();
        end
        @(negedge clk);
        check("div_done_busy", 32'(bus.MduBusy), 0);
        check("div_done_pat", pat(), PatNone);
        tick();

        // Multiply: 5 busy cycles
        bus.MduStartE = 1'b1;
        tick();
        bus.MduStartE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mul_busy%0d", i), 32'(bus.MduBusy), 1);
            check($sformatf("mul_pat%0d", i), pat(), PatHz);
            tick();
        end
        @(negedge clk);
        check("mul_done_busy", 32'(bus.MduBusy), 0);
        check("mul_done_pat", pat(), PatNone);
        tick();
        clear_inputs();

        // Memory wait hides a load-use hazard; an MDU start held in frozen E must not launch
        set_load_use();
        bus.DmReqM = 1'b1; bus.MduStartE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mw_pat%0d", i), pat(), PatMem);
            check($sformatf("mw_busy%0d", i), 32'(bus.MduBusy), 0);
            tick();
        end
        bus.DmReadyM = 1'b1; bus.MduStartE = 1'b0;
        @(negedge clk);
        check("mw_lu_after", pat(), PatHz);
        tick();
        clear_inputs();
        @(negedge clk);
        check("mw_clear", pat(), PatNone);
        tick();

        // MDU counter keeps draining through a memory stall
        bus.MduStartE = 1'b1;
        tick();
        bus.MduStartE = 1'b0;
        bus.DmReqM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mdu_mw_busy%0d", i), 32'(bus.MduBusy), 1);
            tick();
        end
        bus.DmReqM = 1'b0;
        @(negedge clk);
        check("mdu_mw_drained", 32'(bus.MduBusy), 0);
        tick();

        // Long wait: timeout sets after WAIT_MAX cycles, stalls persist, flag is sticky
        bus.DmReqM = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (i == 240) check("to_early", 32'(bus.MemTimeout), 0);
            if (i == 259) begin
                check("to_set", 32'(bus.MemTimeout), 1);
                check("to_pat", pat(), PatMem);
            end
            tick();
        end
        bus.DmReqM = 1'b0;
        @(negedge clk);
        check("to_sticky", 32'(bus.MemTimeout), 1);
        check("to_release_pat", pat(), PatNone);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("to_reset", 32'(bus.MemTimeout), 0);
        tick();

        // Reset in the middle of a divide
        bus.MduStartE = 1'b1; bus.MduDivE = 1'b1;
        tick();
        bus.MduStartE = 1'b0; bus.MduDivE = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.MduUseD = 1'b1;
        @(negedge clk);
        check("rst_div_busy", 32'(bus.MduBusy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_div_hold_pat", pat(), PatNone);
        check("rst_div_hold_busy", 32'(bus.MduBusy), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_div_after_busy", 32'(bus.MduBusy), 0);
        check("rst_div_after_pat", pat(), PatNone);
`ifdef STALL_STATS_EN
        check("stats_stall_zero", stall_cnt, 0);
        check("stats_mem_zero", mem_wait_cnt, 0);
        tick();
        set_load_use();
        tick();
        tick();
        clear_inputs();
        @(negedge clk);
        check("stats_stall_two", stall_cnt, 2);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
